// File: rtl/bios_pkg.sv
// Shared types and byte constants for the bios/UART mode arbiter.
package bios_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    DRAIN_RUN  = 2'd1,
    RUN        = 2'd2,
    DRAIN_BOOT = 2'd3
  } uart_mode_t;

  typedef enum logic {
    SRC_BIOS = 1'b0,
    SRC_CPU  = 1'b1
  } tx_src_t;

  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_B   = 8'h42;

endpackage

// File: rtl/uart_tx_slot.sv
// One-entry registered output stage feeding the UART transmitter.
module uart_tx_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       slot_free
);

  logic [7:0] data_q;
  logic       valid_q;

  assign slot_free = !valid_q | tx_ready;
  assign tx_data   = data_q;
  assign tx_valid  = valid_q;

  // Data is only replaced on a load, so it stays stable while the byte waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (clk_en && slot_free) begin
      valid_q <= load;
      if (load) begin
        data_q <= load_data;
      end
    end
  end

endmodule

// File: rtl/uart_mode_arbiter.sv
// Shares one UART byte stream between the bios command FSM and the CPU,
// sequencing BOOT/RUN mode changes and driving the CPU hold line.
module uart_mode_arbiter
  import bios_pkg::*;
#(
  parameter logic [7:0] ESC_CHAR  = ASCII_ESC,
  parameter int         ESC_COUNT = 3,
  parameter logic [7:0] ACK_CHAR  = ASCII_B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] bios_rx_data,
  output logic       bios_rx_valid,
  input  logic       bios_rx_ready,
  output logic [7:0] cpu_rx_data,
  output logic       cpu_rx_valid,
  input  logic       cpu_rx_ready,
  input  logic [7:0] bios_tx_data,
  input  logic       bios_tx_valid,
  output logic       bios_tx_ready,
  input  logic [7:0] cpu_tx_data,
  input  logic       cpu_tx_valid,
  output logic       cpu_tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       run_req,
  output logic       cpu_hold,
  output logic       boot_mode
);

  localparam int                CNT_W    = $clog2(ESC_COUNT + 1);
  localparam logic [CNT_W-1:0] ESC_LAST = CNT_W'(ESC_COUNT);

  uart_mode_t        state_q, state_d;
  tx_src_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  esc_cnt_q, esc_cnt_d;
  logic [CNT_W-1:0]  esc_inc_s;
  logic              slot_free_s;
  logic              grant_bios_s, grant_cpu_s;
  logic              ack_load_s, load_s;
  logic [7:0]        load_data_s;
  logic              rx_fire_s;

  assign bios_rx_data = rx_data;
  assign cpu_rx_data  = rx_data;
  assign rx_fire_s    = rx_valid & rx_ready;
  assign esc_inc_s    = esc_cnt_q + CNT_W'(1);
  assign cpu_hold     = (state_q != RUN);
  assign boot_mode    = (state_q == BOOT) || (state_q == DRAIN_RUN);

  // RX routing: the byte goes to whichever side owns the stream in this mode.
  always_comb begin
    bios_rx_valid = 1'b0;
    cpu_rx_valid  = 1'b0;
    rx_ready      = 1'b0;
    case (state_q)
      BOOT: begin
        bios_rx_valid = rx_valid;
        rx_ready      = clk_en & bios_rx_ready;
      end
      RUN: begin
        cpu_rx_valid = rx_valid;
        rx_ready     = clk_en & cpu_rx_ready;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  // TX grant: bios only in BOOT, per-byte round robin in RUN, nobody while draining.
  always_comb begin
    grant_bios_s = 1'b0;
    grant_cpu_s  = 1'b0;
    case (state_q)
      BOOT: begin
        grant_bios_s = bios_tx_valid;
      end
      RUN: begin
        if (bios_tx_valid && cpu_tx_valid) begin
          if (last_grant_q == SRC_CPU) begin
            grant_bios_s = 1'b1;
          end else begin
            grant_cpu_s = 1'b1;
          end
        end else begin
          grant_bios_s = bios_tx_valid;
          grant_cpu_s  = cpu_tx_valid;
        end
      end
      default: begin
        grant_bios_s = 1'b0;
      end
    endcase
  end

  assign bios_tx_ready = clk_en & slot_free_s & grant_bios_s;
  assign cpu_tx_ready  = clk_en & slot_free_s & grant_cpu_s;
  assign load_s        = grant_bios_s | grant_cpu_s | ack_load_s;

  // The ACK byte is only ever loaded while draining, when no source is granted.
  always_comb begin
    if (ack_load_s) begin
      load_data_s = ACK_CHAR;
    end else if (grant_cpu_s) begin
      load_data_s = cpu_tx_data;
    end else begin
      load_data_s = bios_tx_data;
    end
  end

  // Mode FSM, escape counter and round-robin history.
  always_comb begin
    state_d      = state_q;
    esc_cnt_d    = esc_cnt_q;
    last_grant_d = last_grant_q;
    ack_load_s   = 1'b0;
    case (state_q)
      BOOT: begin
        if (clk_en && run_req) begin
          state_d = DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        if (clk_en && slot_free_s) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cpu_tx_ready) begin
          last_grant_d = SRC_CPU;
        end else if (bios_tx_ready) begin
          last_grant_d = SRC_BIOS;
        end
        if (rx_fire_s) begin
          if (rx_data == ESC_CHAR) begin
            if (esc_inc_s == ESC_LAST) begin
              esc_cnt_d = '0;
              state_d   = DRAIN_BOOT;
            end else begin
              esc_cnt_d = esc_inc_s;
            end
          end else begin
            esc_cnt_d = '0;
          end
        end
      end
      DRAIN_BOOT: begin
        if (clk_en && slot_free_s) begin
          state_d    = BOOT;
          ack_load_s = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers; everything freezes while clk_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      esc_cnt_q    <= '0;
      last_grant_q <= SRC_CPU;
    end else if (clk_en) begin
      state_q      <= state_d;
      esc_cnt_q    <= esc_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  uart_tx_slot u_tx_slot (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .load      (load_s),
    .load_data (load_data_s),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .slot_free (slot_free_s)
  );

endmodule
